// File: rtl/packet_transmitter.sv
// Packet source: 4 preamble symbols, 3 zero symbols, then BRAM data symbols, each held N beats.
// Define PACKET_TX_GRAY_EN to Gray-map data symbols before constellation mapping.
module packet_transmitter #(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned BRAM_BITDEPTH          = 16,
    parameter int unsigned BRAM_BITWIDTH          = 2
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic [31:0]                           num_samples,
    input  logic [BRAM_BITDEPTH-1:0]              data_len,
    input  logic [1:0]                            p1_sym,
    input  logic signed [15:0]                    amplitude,
    output logic [BRAM_BITDEPTH-1:0]              bram_addr,
    input  logic [BRAM_BITWIDTH-1:0]              bram_dout,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

    typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3, StZero, StData} state_e;

    state_e                   state_q, state_d;
    logic [31:0]              n_q, n_d;
    logic [31:0]              beat_q, beat_d;
    logic [BRAM_BITDEPTH-1:0] len_q, len_d;
    logic [BRAM_BITDEPTH-1:0] idx_q, idx_d;
    logic [BRAM_BITDEPTH-1:0] addr_q, addr_d;
    logic [1:0]               p1_q, p1_d;
    logic [15:0]              amp_q, amp_d;
    logic [1:0]               cur_q, cur_d;
    logic [1:0]               nxt_q, nxt_d;
    logic [1:0]               fetch_q, fetch_d;
    logic                     done_q, done_d;

    logic                     accept;
    logic                     sym_end;
    logic [1:0]               rd_sym;
    logic [1:0]               data_sym;
    logic [31:0]              tx_word;

    function automatic logic [31:0] iq_word(input logic [1:0] s, input logic [15:0] a);
        logic [15:0] na;
        na = -a;
        case (s)
            2'd0:    iq_word = {a, 16'h0000};
            2'd1:    iq_word = {16'h0000, a};
            2'd2:    iq_word = {na, 16'h0000};
            default: iq_word = {16'h0000, na};
        endcase
    endfunction

    assign rd_sym  = bram_dout[1:0];
    assign accept  = m00_axis_tvalid && m00_axis_tready;
    assign sym_end = accept && (beat_q == n_q - 32'd1);

    // fetch_q[1] marks the cycle in which bram_dout carries the launched address' data.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        beat_d  = beat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        p1_d    = p1_q;
        amp_d   = amp_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        fetch_d = {fetch_q[0], 1'b0};
        done_d  = 1'b0;

        if (fetch_q[1]) nxt_d = rd_sym;
        if (accept) beat_d = sym_end ? 32'd0 : beat_q + 32'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StP0;
                    n_d     = (num_samples < 32'd2) ? 32'd2 : num_samples;
                    len_d   = data_len;
                    p1_d    = p1_sym;
                    amp_d   = amplitude;
                    beat_d  = 32'd0;
                    idx_d   = '0;
                end
            end
            StP0: if (sym_end) state_d = StP1;
            StP1: if (sym_end) state_d = StP2;
            StP2: if (sym_end) state_d = StP3;
            StP3: begin
                if (sym_end) begin
                    state_d    = StZero;
                    idx_d      = '0;
                    addr_d     = '0;
                    fetch_d[0] = 1'b1;
                end
            end
            StZero: begin
                if (sym_end) begin
                    if (idx_q == BRAM_BITDEPTH'(2)) begin
                        state_d = StData;
                        idx_d   = '0;
                        cur_d   = fetch_q[1] ? rd_sym : nxt_q;
                        if (len_q != '0) begin
                            addr_d     = BRAM_BITDEPTH'(1);
                            fetch_d[0] = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + BRAM_BITDEPTH'(1);
                    end
                end
            end
            StData: begin
                if (sym_end) begin
                    if (idx_q == len_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + BRAM_BITDEPTH'(1);
                        cur_d = fetch_q[1] ? rd_sym : nxt_q;
                        // Skip the prefetch past the last address so bram_addr never wraps.
                        if (idx_q + BRAM_BITDEPTH'(1) != len_q) begin
                            addr_d     = idx_q + BRAM_BITDEPTH'(2);
                            fetch_d[0] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q <= StIdle;
            n_q     <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            p1_q    <= '0;
            amp_q   <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            fetch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            p1_q    <= p1_d;
            amp_q   <= amp_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            fetch_q <= fetch_d;
            done_q  <= done_d;
        end
    end

`ifdef PACKET_TX_GRAY_EN
    always_comb begin
        unique case (cur_q)
            2'b00:   data_sym = 2'd0;
            2'b01:   data_sym = 2'd1;
            2'b11:   data_sym = 2'd2;
            default: data_sym = 2'd3;
        endcase
    end
`else
    assign data_sym = cur_q;
`endif

    always_comb begin
        tx_word = '0;
        unique case (state_q)
            StP0, StP2, StP3: tx_word = iq_word(2'd0, amp_q);
            StP1:             tx_word = iq_word(p1_q, amp_q);
            StData:           tx_word = iq_word(data_sym, amp_q);
            default:          tx_word = '0;
        endcase
    end

    assign m00_axis_tvalid = (state_q != StIdle);
    assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(tx_word);
    assign m00_axis_tlast  = (state_q == StData) && (idx_q == len_q) && (beat_q == n_q - 32'd1);
    assign m00_axis_tstrb  = '1;
    assign bram_addr       = addr_q;
    assign busy            = (state_q != StIdle);
    assign done            = done_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: table of packet configs plus reset/back-to-back sequences.
module tb_packet_transmitter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        m00_axis_areset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] num_samples;
    logic [15:0] data_len;
    logic [1:0]  p1_sym;
    logic [15:0] amplitude;
    logic [15:0] bram_addr;
    logic [1:0]  bram_dout;
    logic        m00_axis_tready;
    logic        m00_axis_tvalid;
    logic [31:0] m00_axis_tdata;
    logic        m00_axis_tlast;
    logic [3:0]  m00_axis_tstrb;

    logic [1:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int          ns;
        int          dl;
        logic [1:0]  p1;
        logic [15:0] amp;
        logic [31:0] ram;
        bit          rmode;
        int          exp_beats;
        logic [31:0] exp_p1;
        logic [31:0] exp_d0;
    } pkt_t;

    pkt_t tbl [7];

    packet_transmitter #(
        .C_M00_AXIS_TDATA_WIDTH(32),
        .BRAM_BITDEPTH(16),
        .BRAM_BITWIDTH(2)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_areset(m00_axis_areset),
        .start(start),
        .busy(busy),
        .done(done),
        .num_samples(num_samples),
        .data_len(data_len),
        .p1_sym(p1_sym),
        .amplitude(amplitude),
        .bram_addr(bram_addr),
        .bram_dout(bram_dout),
        .m00_axis_tready(m00_axis_tready),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tstrb(m00_axis_tstrb)
    );

    // Registered read of the DUT's registered address: data lands two edges after launch.
    always @(posedge clk) bram_dout <= mem[bram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_iq(input logic [1:0] s, input logic [15:0] a);
        logic [15:0] neg;
        neg = 16'h0000 - a;
        if (s == 2'd0)      model_iq = {a, 16'h0000};
        else if (s == 2'd1) model_iq = {16'h0000, a};
        else if (s == 2'd2) model_iq = {neg, 16'h0000};
        else                model_iq = {16'h0000, neg};
    endfunction

    function automatic logic [1:0] model_data_sym(input logic [1:0] s);
`ifdef PACKET_TX_GRAY_EN
        if (s == 2'b11)      model_data_sym = 2'd2;
        else if (s == 2'b10) model_data_sym = 2'd3;
        else                 model_data_sym = s;
`else
        model_data_sym = s;
`endif
    endfunction

    task automatic run_packet(input pkt_t p, input bit poke, input bit chain, input bit prestarted,
                              input string tag);
        logic [31:0] exp_w[$];
        logic [31:0] got_w[$];
        logic [31:0] dat, prev_dat;
        logic        vld, lst, rdy, prev_stall;
        int          n, iter, gaps, stall_err, last_idx, mism;
        bit          timed_out;
        n = (p.ns < 2) ? 2 : p.ns;
        iter = 0; gaps = 0; stall_err = 0; last_idx = -1; mism = 0;
        timed_out = 0; prev_stall = 0; prev_dat = '0;
        for (int s = 0; s < 8 + p.dl; s++) begin
            logic [31:0] w;
            if (s == 1)      w = model_iq(p.p1, p.amp);
            else if (s < 4)  w = model_iq(2'd0, p.amp);
            else if (s < 7)  w = 32'h0;
            else             w = model_iq(model_data_sym(p.ram[2*(s-7) +: 2]), p.amp);
            for (int b = 0; b < n; b++) exp_w.push_back(w);
        end
        for (int i = 0; i < 16; i++) mem[i] = p.ram[2*i +: 2];
        if (!prestarted) begin
            num_samples = 32'(p.ns);
            data_len    = 16'(p.dl);
            p1_sym      = p.p1;
            amplitude   = p.amp;
            start       = 1'b1;
        end
        @(posedge clk); #1;
        start       = 1'b0;
        num_samples = 32'd7;
        data_len    = 16'd9;
        p1_sym      = ~p.p1;
        amplitude   = 16'h5555;
        while (1) begin
            if (iter >= 3000) begin
                timed_out = 1;
                break;
            end
            iter++;
            if (!m00_axis_tvalid) gaps++;
            if (prev_stall && (m00_axis_tdata !== prev_dat || !m00_axis_tvalid)) stall_err++;
            start = poke && (iter == 6);
            rdy = p.rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            m00_axis_tready = rdy;
            vld = m00_axis_tvalid;
            dat = m00_axis_tdata;
            lst = m00_axis_tlast;
            prev_stall = vld && !rdy;
            prev_dat = dat;
            @(posedge clk); #1;
            if (vld && rdy) begin
                got_w.push_back(dat);
                if (lst) begin
                    last_idx = got_w.size() - 1;
                    break;
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            if (got_w[i] !== exp_w[i]) mism++;
        check({tag, " timeout"}, 64'(timed_out), 64'd0);
        check({tag, " beat count"}, 64'(got_w.size()), 64'(p.exp_beats));
        check({tag, " beat data mismatches"}, 64'(mism), 64'd0);
        check({tag, " p1 word"}, (got_w.size() > n) ? 64'(got_w[n]) : 64'hDEAD, 64'(p.exp_p1));
        check({tag, " first data word"}, (got_w.size() > 7*n) ? 64'(got_w[7*n]) : 64'hDEAD,
              64'(p.exp_d0));
        check({tag, " tlast index"}, 64'(last_idx), 64'(p.exp_beats - 1));
        check({tag, " tvalid gaps"}, 64'(gaps), 64'd0);
        check({tag, " stall changes"}, 64'(stall_err), 64'd0);
        check({tag, " done pulse"}, 64'(done), 64'd1);
        check({tag, " busy on done"}, 64'(busy), 64'd0);
        check({tag, " tvalid on done"}, 64'(m00_axis_tvalid), 64'd0);
        if (chain) begin
            num_samples = 32'(p.ns);
            data_len    = 16'(p.dl);
            p1_sym      = p.p1;
            amplitude   = p.amp;
            start       = 1'b1;
        end else begin
            @(posedge clk); #1;
            check({tag, " done falls"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, k, done_seen;
        m00_axis_areset = 1'b1;
        start           = 1'b0;
        num_samples     = '0;
        data_len        = '0;
        p1_sym          = '0;
        amplitude       = '0;
        m00_axis_tready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 2'd0;

        //         ns dl p1   amp      ram         rm beats p1 word       first data word
        tbl[0] = '{4, 3, 2'd1, 16'h7FFF, 32'hE4,   0, 44, 32'h00007FFF, 32'h7FFF0000};
        tbl[1] = '{4, 3, 2'd1, 16'h7FFF, 32'hE4,   1, 44, 32'h00007FFF, 32'h7FFF0000};
        tbl[2] = '{0, 2, 2'd2, 16'h1234, 32'h2D,   0, 20, 32'hEDCC0000, 32'h00001234};
        tbl[3] = '{1, 0, 2'd3, 16'h0100, 32'h0,    0, 16, 32'h0000FF00, 32'h01000000};
        tbl[4] = '{3, 5, 2'd0, 16'h8000, 32'h385,  1, 39, 32'h80000000, 32'h00008000};
        tbl[5] = '{2, 7, 2'd1, 16'h0001, 32'h1BE4, 0, 30, 32'h00000001, 32'h00010000};
`ifdef PACKET_TX_GRAY_EN
        tbl[6] = '{2, 1, 2'd0, 16'h7FFF, 32'hB,    0, 18, 32'h7FFF0000, 32'h80010000};
`else
        tbl[6] = '{2, 1, 2'd0, 16'h7FFF, 32'hB,    0, 18, 32'h7FFF0000, 32'h00008001};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset tvalid", 64'(m00_axis_tvalid), 64'd0);
        check("reset tlast", 64'(m00_axis_tlast), 64'd0);
        check("reset tdata", 64'(m00_axis_tdata), 64'd0);
        check("reset tstrb", 64'(m00_axis_tstrb), 64'hF);
        check("reset bram_addr", 64'(bram_addr), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        m00_axis_areset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_packet(tbl[i], 1'b0, 1'b0, 1'b0, $sformatf("pkt%0d", i));

        // Start while busy is ignored; start on the done cycle launches the next packet.
        run_packet(tbl[3], 1'b1, 1'b1, 1'b0, "busy_start");
        run_packet(tbl[3], 1'b0, 1'b0, 1'b1, "done_start");

        // Reset while DATA beat 10 is on the bus.
        for (int i = 0; i < 16; i++) mem[i] = tbl[0].ram[2*i +: 2];
        num_samples = 32'd4;
        data_len    = 16'd3;
        p1_sym      = 2'd1;
        amplitude   = 16'h7FFF;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m00_axis_tready = 1'b1;
        cnt = 0;
        k = 0;
        while (cnt < 38 && k < 500) begin
            if (m00_axis_tvalid) cnt++;
            @(posedge clk); #1;
            k++;
        end
        check("rst reach beat", 64'(k >= 500), 64'd0);
`ifdef PACKET_TX_GRAY_EN
        check("rst beat38 data", 64'(m00_axis_tdata), 64'h00008001);
`else
        check("rst beat38 data", 64'(m00_axis_tdata), 64'h80010000);
`endif
        m00_axis_areset = 1'b1;
        @(posedge clk); #1;
        m00_axis_areset = 1'b0;
        check("rst tvalid", 64'(m00_axis_tvalid), 64'd0);
        check("rst tlast", 64'(m00_axis_tlast), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst bram_addr", 64'(bram_addr), 64'd0);
        done_seen = 0;
        repeat (5) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check("rst no done", 64'(done_seen), 64'd0);
        run_packet(tbl[0], 1'b0, 1'b0, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_transmitter.md
PACKET_TRANSMITTER -- requirements
Module: packet_transmitter

Interface
REQ-001 SHALL have parameters: C_M00_AXIS_TDATA_WIDTH, 32, sample width {I[31:16],Q[15:0]}; BRAM_BITDEPTH, 16, symbol-RAM address width; BRAM_BITWIDTH, 2, symbol width.
REQ-002 SHALL have ports: m00_axis_aclk in 1 sole clock; m00_axis_areset in 1 reset, synchronous, active-high; start in 1 packet request pulse; busy out 1 packet in progress; done out 1 one-cycle end pulse.
REQ-003 SHALL have ports: num_samples in 32 samples per symbol; data_len in BRAM_BITDEPTH last data address; p1_sym in 2 second-preamble symbol; amplitude in 16 signed constellation magnitude A.
REQ-004 SHALL have ports: bram_addr out BRAM_BITDEPTH read address; bram_dout in BRAM_BITWIDTH read data, 2-cycle latency, always enabled.
REQ-005 SHALL have ports: m00_axis_tready in 1; m00_axis_tvalid out 1; m00_axis_tdata out 32; m00_axis_tlast out 1; m00_axis_tstrb out 4.

Function
REQ-006 SHALL map symbol s to (I,Q): 0 -> (A,0), 1 -> (0,A), 2 -> (-A,0), 3 -> (0,-A); -A is two's-complement negate, 16-bit wrap.
REQ-007 SHALL use states IDLE, P0, P1, P2, P3, ZERO, DATA; IDLE -> P0 on start; P0->P1->P2->P3->ZERO->DATA->IDLE.
REQ-008 SHALL emit P0, P2, P3 as symbol 0, P1 as latched p1_sym, ZERO as (0,0) for exactly 3 symbol periods, DATA as bram_dout symbols from addresses 0..data_len (data_len+1 symbols).
REQ-009 SHALL latch num_samples, data_len, p1_sym, amplitude on the start-accepting edge; later input changes ignored until next packet.
REQ-010 SHALL hold each symbol for N accepted beats, N = max(latched num_samples, 2); a beat is accepted on tvalid&&tready.
REQ-011 SHALL assert tvalid continuously from the cycle after start acceptance until the final beat is accepted; tdata/tlast stable while tvalid&&!tready.
REQ-012 SHALL assert tlast only on the last beat of the last data symbol; tstrb constant 4'hF.
REQ-013 SHALL prefetch: drive address k+1 on the first cycle of data symbol k (address 0 on first ZERO cycle), capture bram_dout exactly 2 cycles later into a next-symbol register; no tvalid gaps at symbol boundaries.
REQ-014 SHALL keep bram_addr at its last value when not fetching; no address wrap (data_len max 2^BRAM_BITDEPTH-1).
REQ-015 SHALL assert busy from start acceptance through final beat acceptance; done pulses the cycle after the final beat, busy low that cycle.
REQ-016 SHALL ignore start while busy; start on the done cycle is accepted (back-to-back packets).
REQ-017 SHALL produce 4 preamble + 3 zero + data_len+1 symbols, i.e. (8+data_len)*N beats per packet.

Reset
REQ-018 SHALL on reset: state IDLE, tvalid 0, tlast 0, tdata 0, tstrb 4'hF, bram_addr 0, busy 0, done 0, counters 0.
REQ-019 SHALL abort any packet on reset mid-operation: tvalid low the cycle after the reset edge, no tlast, no done.

Configuration
REQ-020 SHALL support macro PACKET_TX_GRAY_EN: defined -> data symbols Gray-mapped before REQ-006 (00->0, 01->1, 11->2, 10->3); undefined -> natural mapping; preamble symbols never remapped.

Verification
REQ-021 SHALL test basic packet: A=16'h7FFF, num_samples=4, data_len=3, p1_sym=1, RAM {0,1,2,3}, tready=1 -> 44 beats, P1=0x00007FFF, 12 zero beats, data 0x7FFF0000,0x00007FFF,0x80010000,0x00008001, tlast beat 44, done next cycle.
REQ-022 SHALL test backpressure: random 50% tready, same config -> beat sequence identical to REQ-021, tdata stable during stalls.
REQ-023 SHALL test num_samples=0 and 1 -> each symbol held 2 beats, tvalid never drops mid-packet, prefetch data correct.
REQ-024 SHALL test start while busy plus start on done cycle -> first ignored, second starts new packet with no idle beat gap beyond one cycle.
REQ-025 SHALL test reset asserted in DATA beat 10 -> tvalid 0 next cycle, no done, next start produces full correct packet.
REQ-026 SHALL test with PACKET_TX_GRAY_EN, RAM {3,2} -> data (-A,0) then (0,-A); without macro -> (0,-A) then (-A,0).
